// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared states, rate codes and default periods for the PWM burst sequencer
package pwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] SEL_00  = 2'b00;
    localparam logic [1:0] SEL_01  = 2'b01;
    localparam logic [1:0] SEL_10  = 2'b10;
    localparam logic [1:0] SEL_END = 2'b11;

    localparam int DEF_PERIOD_00 = 10000;
    localparam int DEF_PERIOD_01 = 1000;
    localparam int DEF_PERIOD_10 = 100;

endpackage

// File: rtl/pwm_period_counter.sv
// rtl/pwm_period_counter.sv - free-running period counter with wrap and half-period decode
module pwm_period_counter #(
    parameter int CNT_W = 14
) (
    input  logic             clk_in,
    input  logic             refresh,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             hi
);

    assign last = (cnt == period - CNT_W'(1));
    assign hi   = (cnt < (period >> 1));

    always_ff @(posedge clk_in) begin
        if (!refresh || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_burst_sequencer.sv
// rtl/pwm_burst_sequencer.sv - plays a 4-entry {rate, repeat} table as back-to-back PWM segments
module pwm_burst_sequencer
    import pwm_pkg::*;
#(
    parameter int CNT_W     = 14,
    parameter int REP_W     = 8,
    parameter int N_SEG     = 4,
    parameter int PERIOD_00 = DEF_PERIOD_00,
    parameter int PERIOD_01 = DEF_PERIOD_01,
    parameter int PERIOD_10 = DEF_PERIOD_10
) (
    input  logic             clk_in,
    input  logic             refresh,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_idx,
    input  logic [1:0]       cfg_sel,
    input  logic [REP_W-1:0] cfg_reps,
    output logic             clk_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       seg_idx,
    output logic             cfg_err
);

    state_t             state_q, state_d;
    logic [1:0]         tbl_sel  [N_SEG];
    logic [REP_W-1:0]   tbl_reps [N_SEG];
    logic [REP_W-1:0]   rep, reps_q;
    logic [CNT_W-1:0]   period_q, sel_period, cnt;
    logic               cnt_last, cnt_hi, rep_last;
    logic [1:0]         cur_sel;
    logic [REP_W-1:0]   cur_reps;

    assign cur_sel  = tbl_sel[seg_idx];
    assign cur_reps = tbl_reps[seg_idx];
    assign rep_last = (rep == reps_q - REP_W'(1));

    assign busy    = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_NEXT);
    assign done    = (state_q == ST_DONE);
    assign clk_out = (state_q == ST_RUN) && cnt_hi;

    // Counter sits at zero outside RUN, so every segment starts on a fresh period.
    pwm_period_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_in  (clk_in),
        .refresh (refresh),
        .clr     ((state_q != ST_RUN) || abort),
        .en      (state_q == ST_RUN),
        .period  (period_q),
        .cnt     (cnt),
        .last    (cnt_last),
        .hi      (cnt_hi)
    );

    always_comb begin
        sel_period = CNT_W'(PERIOD_00);
        case (cur_sel)
            SEL_01:  sel_period = CNT_W'(PERIOD_01);
            SEL_10:  sel_period = CNT_W'(PERIOD_10);
            default: sel_period = CNT_W'(PERIOD_00);
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (cur_sel == SEL_END)      state_d = ST_DONE;
                else if (cur_reps == '0)     state_d = ST_NEXT;
                else                         state_d = ST_RUN;
            end
            ST_RUN:  if (cnt_last && rep_last) state_d = ST_NEXT;
            ST_NEXT: state_d = (seg_idx == 2'd3) ? ST_DONE : ST_LOAD;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_in) begin
        if (!refresh) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_in) begin
        if (!refresh) begin
            for (int i = 0; i < N_SEG; i++) begin
                tbl_sel[i]  <= SEL_END;
                tbl_reps[i] <= '0;
            end
            rep      <= '0;
            reps_q   <= '0;
            period_q <= '0;
            seg_idx  <= 2'd0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_we && busy;
            if (cfg_we && !busy) begin
                tbl_sel[cfg_idx]  <= cfg_sel;
                tbl_reps[cfg_idx] <= cfg_reps;
            end
            if (abort) begin
                rep     <= '0;
                seg_idx <= 2'd0;
            end else begin
                case (state_q)
                    ST_IDLE: seg_idx <= 2'd0;
                    ST_LOAD: if (state_d == ST_RUN) begin
                        period_q <= sel_period;
                        reps_q   <= cur_reps;
                        rep      <= '0;
                    end
                    ST_RUN:  if (cnt_last && !rep_last) rep <= rep + REP_W'(1);
                    ST_NEXT: if (seg_idx != 2'd3) seg_idx <= seg_idx + 2'd1;
                    ST_DONE: seg_idx <= 2'd0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_burst_sequencer.sv
// tb/tb_pwm_burst_sequencer.sv - directed self-checking bench for pwm_burst_sequencer
module tb_pwm_burst_sequencer;

    logic       clk_in = 1'b0;
    logic       refresh, start, abort, cfg_we;
    logic [1:0] cfg_idx, cfg_sel;
    logic [7:0] cfg_reps;
    logic       clk_out, busy, done, cfg_err;
    logic [1:0] seg_idx;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [63:0]  exp_c, obs_c, exp_d, obs_d;
    logic [127:0] exp_s, obs_s;

    always #5 clk_in = ~clk_in;

    pwm_burst_sequencer #(
        .CNT_W(14), .REP_W(8), .N_SEG(4),
        .PERIOD_00(8), .PERIOD_01(6), .PERIOD_10(4)
    ) dut (
        .clk_in   (clk_in),
        .refresh  (refresh),
        .start    (start),
        .abort    (abort),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_sel  (cfg_sel),
        .cfg_reps (cfg_reps),
        .clk_out  (clk_out),
        .busy     (busy),
        .done     (done),
        .seg_idx  (seg_idx),
        .cfg_err  (cfg_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [1:0] sel, input logic [7:0] reps);
        cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_reps = reps;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic clear_vec();
        exp_c = '0; obs_c = '0; exp_d = '0; obs_d = '0; exp_s = '0; obs_s = '0;
    endtask

    task automatic add(input logic c, input logic d, input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            exp_c = {exp_c[62:0], c};
            exp_d = {exp_d[62:0], d};
            exp_s = {exp_s[125:0], s};
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            start  = 1'b0;
            cfg_we = 1'b0;
            obs_c = {obs_c[62:0], clk_out};
            obs_d = {obs_d[62:0], done};
            obs_s = {obs_s[125:0], seg_idx};
        end
    endtask

    task automatic build_t1();
        clear_vec();
        add(0, 0, 2'd0, 1);
        add(1, 0, 2'd0, 4); add(0, 0, 2'd0, 4);
        add(1, 0, 2'd0, 4); add(0, 0, 2'd0, 4);
        add(0, 0, 2'd0, 1);
        add(0, 0, 2'd1, 1);
        add(0, 1, 2'd1, 1);
        add(0, 0, 2'd0, 1);
    endtask

    task automatic build_t5();
        clear_vec();
        add(0, 0, 2'd0, 1);
        add(0, 1, 2'd0, 1);
        add(0, 0, 2'd0, 1);
    endtask

    task automatic check_vecs(input string tag);
        check({tag, "_clk"},  {64'd0, obs_c}, {64'd0, exp_c});
        check({tag, "_done"}, {64'd0, obs_d}, {64'd0, exp_d});
        check({tag, "_seg"},  obs_s, exp_s);
    endtask

    initial begin
        refresh = 1'b0; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        cfg_idx = 2'd0; cfg_sel = 2'd0; cfg_reps = 8'd0;
        step(); step();
        check("reset_outputs", {123'd0, clk_out, busy, done, seg_idx, cfg_err}, 128'd0);
        refresh = 1'b1;
        step();

        // T1: one segment of two 8-cycle periods
        cfg_write(2'd0, 2'b00, 8'd2);
        check("idle_write_no_err", {127'd0, cfg_err}, 128'd0);
        build_t1();
        start = 1'b1;
        run(21);
        check_vecs("t1");
        check("t1_idle_busy", {127'd0, busy}, 128'd0);

        // T2: mixed rates, skipped entry; entry 0 written at the same edge as start
        cfg_write(2'd1, 2'b10, 8'd2);
        cfg_write(2'd2, 2'b00, 8'd0);
        cfg_write(2'd3, 2'b11, 8'd0);
        clear_vec();
        add(0, 0, 2'd0, 1);
        add(1, 0, 2'd0, 3); add(0, 0, 2'd0, 3);
        add(0, 0, 2'd0, 1);
        add(0, 0, 2'd1, 1);
        add(1, 0, 2'd1, 2); add(0, 0, 2'd1, 2);
        add(1, 0, 2'd1, 2); add(0, 0, 2'd1, 2);
        add(0, 0, 2'd1, 1);
        add(0, 0, 2'd2, 1);
        add(0, 0, 2'd2, 1);
        add(0, 0, 2'd3, 1);
        add(0, 1, 2'd3, 1);
        add(0, 0, 2'd0, 1);
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sel = 2'b01; cfg_reps = 8'd1;
        start = 1'b1;
        run(23);
        check_vecs("t2");

        // T3: abort during the second period
        cfg_write(2'd0, 2'b00, 8'd2);
        cfg_write(2'd1, 2'b11, 8'd0);
        clear_vec();
        start = 1'b1;
        run(12);
        check("t3_pre_abort_hi", {127'd0, clk_out}, 128'd1);
        check("t3_pre_abort_busy", {127'd0, busy}, 128'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t3_after_abort", {124'd0, clk_out, busy, done, seg_idx}, 128'd0);
        clear_vec();
        run(20);
        check("t3_no_done", {64'd0, obs_d}, 128'd0);
        check("t3_stays_low", {64'd0, obs_c}, 128'd0);

        // T4: write while busy is dropped and flagged
        start = 1'b1;
        run(4);
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sel = 2'b10; cfg_reps = 8'd1;
        step();
        cfg_we = 1'b0;
        check("t4_cfg_err_pulse", {127'd0, cfg_err}, 128'd1);
        step();
        check("t4_cfg_err_clear", {127'd0, cfg_err}, 128'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        build_t1();
        start = 1'b1;
        run(21);
        check_vecs("t4_rerun");

        // T5: after reset every entry is an end marker
        refresh = 1'b0;
        step();
        refresh = 1'b1;
        build_t5();
        start = 1'b1;
        run(3);
        check_vecs("t5");

        // T6: reset mid-RUN clears outputs and the table
        cfg_write(2'd0, 2'b00, 8'd2);
        clear_vec();
        start = 1'b1;
        run(5);
        check("t6_pre_reset_hi", {127'd0, clk_out}, 128'd1);
        refresh = 1'b0;
        step();
        check("t6_reset_outputs", {123'd0, clk_out, busy, done, seg_idx, cfg_err}, 128'd0);
        refresh = 1'b1;
        build_t5();
        start = 1'b1;
        run(3);
        check_vecs("t6_table_cleared");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
